hdc_msg_loader: RTL and testbench
=================================

Name: hdc_msg_loader

Overview:
Upstream front end of the HDC spam classifier. It receives a byte stream carrying framed SMS messages from the UART/host side and assembles each frame into the flat message bus, length and label that the classifier core consumes. It pulses msg_valid once per good frame, then holds its outputs stable and stalls input until the core returns compute_done. Bad frames are dropped and flagged.

Parameters:
MAX_LENGTH, 200, maximum payload characters; msg bus is MAX_LENGTH*8 bits.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CYCLES, 100000, idle cycles allowed between bytes inside a frame (used only with the optional feature).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
in_data  in  8  stream byte
in_valid  in  1  byte present
in_ready  out  1  loader accepts a byte this cycle
msg  out  MAX_LENGTH*8  character i at msg[i*8 +: 8]; bytes at or beyond length are zero
length  out  8  payload length, 1..MAX_LENGTH
label  out  2  frame label (0 = spam, 1 = ham)
msg_valid  out  1  one-cycle pulse: msg/length/label are valid
compute_done  in  1  classifier finished the current message
frame_err  out  1  one-cycle pulse when a frame is dropped
frame_cnt  out  16  count of good frames issued; wraps at 65535 -> 0

Behaviour:
- Interface: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: in_ready=0, msg=0, length=0, label=0, msg_valid=0, frame_err=0, frame_cnt=0. FSM returns to S_SYNC, where in_ready rises one cycle after rst deasserts. Reset mid-frame or mid-compute discards everything.
- A byte transfers when in_valid && in_ready on a rising edge.
- FSM:
  - S_SYNC: in_ready=1. SYNC_BYTE -> clear msg to zero, go to S_LABEL. Any other byte is discarded silently.
  - S_LABEL: byte[7:0] must be 0 or 1. Valid -> label<=byte[1:0], go to S_LEN. Otherwise -> frame_err pulse, go to S_SYNC.
  - S_LEN: byte 0 or byte > MAX_LENGTH -> frame_err pulse, go to S_SYNC. Otherwise length<=byte, byte index <=0, go to S_PAYLOAD.
  - S_PAYLOAD: each byte is written to msg[idx*8 +: 8] and idx increments. When the byte at idx==length-1 is accepted, go to S_FIRE.
  - S_FIRE: in_ready=0. msg_valid=1 for exactly this cycle; frame_cnt increments. Go to S_BUSY.
  - S_BUSY: in_ready=0. msg, length and label hold stable. compute_done=1 -> S_SYNC (in_ready=1 on the next cycle).
- Latency: msg_valid asserts on the cycle after the last payload byte is accepted.
- A compute_done outside S_BUSY is ignored.
- in_ready is a registered function of state only; it has no combinational path from in_valid.
- Payload bytes are not case-folded or filtered; the core does that.
- In S_SYNC, S_LABEL and S_LEN the outputs keep their previous-frame values, except that msg clears on SYNC_BYTE. The core only samples on msg_valid.

Optional Feature:
Macro HDC_LOADER_TIMEOUT_EN.
- Defined: a counter runs in S_LABEL, S_LEN and S_PAYLOAD. It resets on every accepted byte. Reaching TIMEOUT_CYCLES with no accepted byte -> frame_err pulse, return to S_SYNC, partial msg discarded. S_BUSY is never timed out.
- Undefined: no counter. A partial frame waits indefinitely.

Decomposition:
- Package hdc_pkg holds: MAX_LENGTH, SYNC_BYTE, the label constants LABEL_SPAM=0 and LABEL_HAM=1, and the loader state enum (S_SYNC, S_LABEL, S_LEN, S_PAYLOAD, S_FIRE, S_BUSY). The classifier core shares these.
- No sub-module is natural. The timeout counter is small enough to stay inline under the macro.

Test Plan:
- Good frame: A5, 01, 03, 'H','i','!' -> msg_valid pulse 1 cycle after '!'; length=3, label=1; msg[23:0]=24'h2169_48; msg[39:24]=0; frame_cnt=1.
- Backpressure: drive a second frame while in S_BUSY -> in_ready=0 and no byte is consumed. Pulse compute_done -> in_ready=1 next cycle; second frame is accepted intact and frame_cnt=2.
- Bad fields: A5, 02 -> frame_err pulse, back to S_SYNC. A5, 00, 00 -> frame_err. A5, 00, C9 (201) -> frame_err. No msg_valid in any case.
- Resync and zero-fill: junk 3C, 7F, then A5, 00, C8 plus 200 bytes of 'a' -> junk ignored; msg_valid; all 1600 bits = 8'h61; length=200. A following 1-byte frame -> msg[15:8]=0 (cleared).
- Reset mid-payload: assert rst after 2 of 5 payload bytes -> all outputs 0 immediately; a subsequent full frame works and frame_cnt=1.
- With HDC_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16: A5, 01, 04, 'a', then idle 16 cycles -> frame_err pulse, back to S_SYNC, no msg_valid.

Source files
------------

// File: rtl/hdc_pkg.sv
// rtl/hdc_pkg.sv - shared HDC constants, label codes and loader state encoding
package hdc_pkg;

  localparam int MAX_LENGTH = 200;
  localparam int MSG_W      = MAX_LENGTH * 8;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] LABEL_SPAM = 2'd0;
  localparam logic [1:0] LABEL_HAM  = 2'd1;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LABEL,
    S_LEN,
    S_PAYLOAD,
    S_FIRE,
    S_BUSY
  } loader_state_e;

endpackage

// File: rtl/hdc_msg_loader_if.sv
// rtl/hdc_msg_loader_if.sv - byte stream in, assembled message out, compute_done back
interface hdc_msg_loader_if;
  import hdc_pkg::*;

  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [MSG_W-1:0] msg;
  logic [7:0]       length;
  logic [1:0]       label;
  logic             msg_valid;
  logic             compute_done;
  logic             frame_err;
  logic [15:0]      frame_cnt;

  modport master (
    output in_data, in_valid, compute_done,
    input  in_ready, msg, length, label, msg_valid, frame_err, frame_cnt
  );

  modport slave (
    input  in_data, in_valid, compute_done,
    output in_ready, msg, length, label, msg_valid, frame_err, frame_cnt
  );

endinterface

// File: rtl/hdc_msg_loader.sv
// rtl/hdc_msg_loader.sv - frames SYNC/label/length/payload bytes into the classifier message bus
// Optional inter-byte timeout inside a frame: HDC_LOADER_TIMEOUT_EN
module hdc_msg_loader
  import hdc_pkg::*;
`ifdef HDC_LOADER_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 100000)
`endif
(
  input logic             clk,
  input logic             rst,
  hdc_msg_loader_if.slave bus
);

  loader_state_e    state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [7:0]       length_q, length_d;
  logic [7:0]       idx_q, idx_d;
  logic [1:0]       label_q, label_d;
  logic             msg_valid_q, msg_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             take;
  logic             label_ok;

  assign take     = bus.in_valid && in_ready_q;
  assign label_ok = (bus.in_data == {6'd0, LABEL_SPAM}) || (bus.in_data == {6'd0, LABEL_HAM});

`ifdef HDC_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             timed;
  logic             tmo_hit;

  always_comb begin
    timed   = (state_q == S_LABEL) || (state_q == S_LEN) || (state_q == S_PAYLOAD);
    tmo_hit = timed && !take && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    tmo_d   = (!timed || take || tmo_hit) ? '0 : tmo_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    msg_d       = msg_q;
    length_d    = length_q;
    idx_d       = idx_q;
    label_d     = label_q;
    frame_cnt_d = frame_cnt_q;
    msg_valid_d = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_SYNC: begin
        if (take && bus.in_data == SYNC_BYTE) begin
          msg_d   = '0;
          state_d = S_LABEL;
        end
      end
      S_LABEL: begin
        if (take) begin
          if (label_ok) begin
            label_d = bus.in_data[1:0];
            state_d = S_LEN;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_SYNC;
          end
        end
      end
      S_LEN: begin
        if (take) begin
          if (bus.in_data == 8'd0 || bus.in_data > 8'(MAX_LENGTH)) begin
            frame_err_d = 1'b1;
            state_d     = S_SYNC;
          end else begin
            length_d = bus.in_data;
            idx_d    = 8'd0;
            state_d  = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (take) begin
          msg_d[{idx_q, 3'b000} +: 8] = bus.in_data;
          idx_d = idx_q + 8'd1;
          if (idx_q == length_q - 8'd1) begin
            state_d     = S_FIRE;
            msg_valid_d = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
      end
      S_FIRE: begin
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (bus.compute_done) begin
          state_d = S_SYNC;
        end
      end
      default: begin
        state_d = S_SYNC;
      end
    endcase

`ifdef HDC_LOADER_TIMEOUT_EN
    // An abandoned partial frame must not leak into the next one.
    if (tmo_hit) begin
      state_d     = S_SYNC;
      frame_err_d = 1'b1;
      msg_d       = '0;
    end
`endif

    // Ready is decided from the next state so it is a pure register output.
    in_ready_d = (state_d == S_SYNC) || (state_d == S_LABEL) ||
                 (state_d == S_LEN)  || (state_d == S_PAYLOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_SYNC;
      in_ready_q  <= 1'b0;
      msg_q       <= '0;
      length_q    <= 8'd0;
      idx_q       <= 8'd0;
      label_q     <= 2'd0;
      msg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      msg_q       <= msg_d;
      length_q    <= length_d;
      idx_q       <= idx_d;
      label_q     <= label_d;
      msg_valid_q <= msg_valid_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.msg       = msg_q;
  assign bus.length    = length_q;
  assign bus.label     = label_q;
  assign bus.msg_valid = msg_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_hdc_msg_loader.sv
// tb/tb_hdc_msg_loader.sv - randomized and directed self-checking bench for hdc_msg_loader
module tb_hdc_msg_loader;

  localparam int ML = 200;
  localparam int MW = ML * 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   err_cnt = 0;
  int   valid_cnt = 0;
  int   exp_cnt = 0;

  hdc_msg_loader_if bus();

`ifdef HDC_LOADER_TIMEOUT_EN
  hdc_msg_loader #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  hdc_msg_loader dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (bus.msg_valid === 1'b1) valid_cnt++;
      if (bus.frame_err === 1'b1) err_cnt++;
    end
  end

  function automatic logic [MW-1:0] model_msg(input logic [7:0] pl[$]);
    logic [MW-1:0] m = '0;
    foreach (pl[i]) m[i*8 +: 8] = pl[i];
    return m;
  endfunction

  function automatic int first_diff(input logic [MW-1:0] a, input logic [MW-1:0] b);
    for (int i = 0; i < ML; i++) if (a[i*8 +: 8] !== b[i*8 +: 8]) return i;
    return -1;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL send_stall: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] lab, input logic [7:0] len, input logic [7:0] pl[$]);
    send_byte(8'hA5);
    send_byte(lab);
    send_byte(len);
    foreach (pl[i]) send_byte(pl[i]);
  endtask

  task automatic complete();
    @(negedge clk);
    bus.compute_done = 1'b1;
    @(negedge clk);
    bus.compute_done = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b0 || bus.msg !== '0 || bus.length !== 8'd0 || bus.label !== 2'd0 ||
        bus.msg_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_values: rdy=%b len=%0d lab=%0d mv=%b fe=%b cnt=%0d, required all 0",
               bus.in_ready, bus.length, bus.label, bus.msg_valid, bus.frame_err, bus.frame_cnt);
    end
    rst = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL ready_after_release: got %b required 0", bus.in_ready);
    end
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL ready_one_cycle_later: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] pl[$] = '{8'h48, 8'h69, 8'h21};
    send_frame(8'h01, 8'h03, pl);
    exp_cnt = 1;
    total++;
    if (bus.msg_valid !== 1'b1 || bus.length !== 8'd3 || bus.label !== 2'd1) begin
      bad++; $display("FAIL good_frame_fields: mv=%b len=%0d lab=%0d, required 1/3/1", bus.msg_valid, bus.length, bus.label);
    end
    total++;
    if (bus.msg[23:0] !== 24'h216948 || bus.msg[39:24] !== 16'h0) begin
      bad++; $display("FAIL good_frame_msg: got %h required 0000216948", bus.msg[39:0]);
    end
    total++;
    if (bus.frame_cnt !== 16'd1) begin
      bad++; $display("FAIL good_frame_cnt: got %0d required 1", bus.frame_cnt);
    end
    @(negedge clk);
    total++;
    if (bus.msg_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL good_frame_pulse: mv=%b rdy=%b, required 0/0", bus.msg_valid, bus.in_ready);
    end
  endtask

  task automatic test_backpressure();
    int v0 = valid_cnt;
    int stalled_ready = 0;
    logic [7:0] pl[$] = '{8'h6F, 8'h6B};
    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0) stalled_ready++;
    end
    total++;
    if (stalled_ready != 0) begin
      bad++; $display("FAIL busy_ready: in_ready high %0d of 6 cycles, required 0", stalled_ready);
    end
    total++;
    if (bus.msg[23:0] !== 24'h216948 || bus.length !== 8'd3 || bus.label !== 2'd1 || valid_cnt != v0) begin
      bad++; $display("FAIL busy_hold: msg=%h len=%0d lab=%0d extra_valid=%0d, required 216948/3/1/0",
                      bus.msg[23:0], bus.length, bus.label, valid_cnt - v0);
    end
    bus.compute_done = 1'b1;
    @(negedge clk);
    bus.compute_done = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_done: got %b required 1", bus.in_ready);
    end
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    foreach (pl[i]) send_byte(pl[i]);
    exp_cnt = 2;
    total++;
    if (bus.msg_valid !== 1'b1 || bus.length !== 8'd2 || bus.label !== 2'd0 ||
        bus.msg[23:0] !== 24'h006B6F || bus.frame_cnt !== 16'd2) begin
      bad++; $display("FAIL second_frame: mv=%b len=%0d lab=%0d msg=%h cnt=%0d, required 1/2/0/006b6f/2",
                      bus.msg_valid, bus.length, bus.label, bus.msg[23:0], bus.frame_cnt);
    end
    complete();
  endtask

  task automatic test_bad_fields();
    logic [7:0] seqs[3][3] = '{'{8'hA5, 8'h02, 8'h00}, '{8'hA5, 8'h00, 8'h00}, '{8'hA5, 8'h00, 8'hC9}};
    int         lens[3] = '{2, 3, 3};
    for (int s = 0; s < 3; s++) begin
      int e0 = err_cnt;
      int v0 = valid_cnt;
      for (int j = 0; j < lens[s]; j++) send_byte(seqs[s][j]);
      @(negedge clk);
      total++;
      if (err_cnt != e0 + 1 || valid_cnt != v0 || bus.in_ready !== 1'b1) begin
        bad++; $display("FAIL bad_field_%0d: errs=%0d valids=%0d rdy=%b, required 1/0/1",
                        s, err_cnt - e0, valid_cnt - v0, bus.in_ready);
      end
    end
    bus.compute_done = 1'b1;
    @(negedge clk);
    bus.compute_done = 1'b0;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1 || bus.frame_cnt !== 16'(exp_cnt)) begin
      bad++; $display("FAIL stray_done: rdy=%b cnt=%0d, required 1/%0d", bus.in_ready, bus.frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_resync_zero_fill();
    logic [7:0]    pl[$];
    logic [7:0]    one[$] = '{8'h5A};
    logic [MW-1:0] exp_m;
    for (int i = 0; i < ML; i++) pl.push_back(8'h61);
    send_byte(8'h3C);
    send_byte(8'h7F);
    send_frame(8'h00, 8'hC8, pl);
    exp_cnt++;
    exp_m = model_msg(pl);
    total++;
    if (bus.msg_valid !== 1'b1 || bus.length !== 8'd200 || bus.msg !== exp_m || bus.frame_cnt !== 16'(exp_cnt)) begin
      bad++; $display("FAIL full_frame: mv=%b len=%0d first_bad_byte=%0d cnt=%0d, required 1/200/-1/%0d",
                      bus.msg_valid, bus.length, first_diff(bus.msg, exp_m), bus.frame_cnt, exp_cnt);
    end
    complete();
    send_frame(8'h01, 8'h01, one);
    exp_cnt++;
    exp_m = model_msg(one);
    total++;
    if (bus.msg_valid !== 1'b1 || bus.msg[15:8] !== 8'h00 || bus.msg !== exp_m || bus.length !== 8'd1) begin
      bad++; $display("FAIL zero_fill: mv=%b msg[15:8]=%h first_bad_byte=%0d len=%0d, required 1/00/-1/1",
                      bus.msg_valid, bus.msg[15:8], first_diff(bus.msg, exp_m), bus.length);
    end
    complete();
  endtask

  task automatic test_reset_mid_payload();
    logic [7:0]    pl[$] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    logic [MW-1:0] exp_m = model_msg(pl);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h31);
    send_byte(8'h32);
    rst = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b0 || bus.msg !== '0 || bus.length !== 8'd0 || bus.label !== 2'd0 ||
        bus.msg_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.frame_cnt !== 16'd0) begin
      bad++; $display("FAIL async_reset: rdy=%b len=%0d lab=%0d mv=%b fe=%b cnt=%0d, required all 0",
                      bus.in_ready, bus.length, bus.label, bus.msg_valid, bus.frame_err, bus.frame_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(8'h01, 8'h05, pl);
    exp_cnt = 1;
    total++;
    if (bus.msg_valid !== 1'b1 || bus.msg !== exp_m || bus.frame_cnt !== 16'd1 || bus.length !== 8'd5) begin
      bad++; $display("FAIL after_reset_frame: mv=%b first_bad_byte=%0d cnt=%0d len=%0d, required 1/-1/1/5",
                      bus.msg_valid, first_diff(bus.msg, exp_m), bus.frame_cnt, bus.length);
    end
    complete();
  endtask

  task automatic test_random_frames();
    for (int it = 0; it < 25; it++) begin
      int         e0 = err_cnt;
      int         v0 = valid_cnt;
      int         kind = $urandom_range(0, 4);
      logic [7:0] pl[$];
      logic [7:0] b;
      repeat ($urandom_range(0, 2)) begin
        do b = 8'($urandom); while (b == 8'hA5);
        send_byte(b);
      end
      if (kind == 0) begin
        case ($urandom_range(0, 2))
          0: begin send_byte(8'hA5); send_byte(8'($urandom_range(2, 255))); end
          1: begin send_byte(8'hA5); send_byte(8'($urandom_range(0, 1))); send_byte(8'h00); end
          default: begin send_byte(8'hA5); send_byte(8'($urandom_range(0, 1))); send_byte(8'($urandom_range(201, 255))); end
        endcase
        @(negedge clk);
        total++;
        if (err_cnt != e0 + 1 || valid_cnt != v0) begin
          bad++; $display("FAIL rand_bad_%0d: errs=%0d valids=%0d, required 1/0", it, err_cnt - e0, valid_cnt - v0);
        end
      end else begin
        logic [7:0]    lab = 8'($urandom_range(0, 1));
        int            len = ($urandom_range(0, 7) == 0) ? ML : $urandom_range(1, 30);
        logic [MW-1:0] exp_m;
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
        exp_m = model_msg(pl);
        send_byte(8'hA5);
        send_byte(lab);
        send_byte(8'(len));
        foreach (pl[i]) begin
          send_byte(pl[i]);
          if (i + 1 < len && $urandom_range(0, 9) == 0) begin
            bus.compute_done = 1'b1;
            @(negedge clk);
            bus.compute_done = 1'b0;
          end
        end
        exp_cnt++;
        total++;
        if (bus.msg_valid !== 1'b1 || bus.length !== 8'(len) || bus.label !== lab[1:0] ||
            bus.msg !== exp_m || bus.frame_cnt !== 16'(exp_cnt) || err_cnt != e0) begin
          bad++; $display("FAIL rand_good_%0d: mv=%b len=%0d/%0d lab=%0d/%0d first_bad_byte=%0d cnt=%0d/%0d errs=%0d",
                          it, bus.msg_valid, bus.length, len, bus.label, lab, first_diff(bus.msg, exp_m),
                          bus.frame_cnt, exp_cnt, err_cnt - e0);
        end
        repeat ($urandom_range(1, 3)) @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b0) begin
          bad++; $display("FAIL rand_busy_%0d: in_ready=%b required 0", it, bus.in_ready);
        end
        complete();
      end
    end
  endtask

`ifdef HDC_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    int e0 = err_cnt;
    int v0 = valid_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h04);
    send_byte(8'h61);
    repeat (14) @(negedge clk);
    total++;
    if (err_cnt != e0) begin
      bad++; $display("FAIL timeout_early: errs=%0d required 0", err_cnt - e0);
    end
    repeat (4) @(negedge clk);
    total++;
    if (err_cnt != e0 + 1 || valid_cnt != v0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL timeout_fire: errs=%0d valids=%0d rdy=%b, required 1/0/1",
                      err_cnt - e0, valid_cnt - v0, bus.in_ready);
    end
  endtask
`endif

  initial begin
    bus.in_data      = 8'h00;
    bus.in_valid     = 1'b0;
    bus.compute_done = 1'b0;
    test_reset();
    test_good_frame();
    test_backpressure();
    test_bad_fields();
    test_resync_zero_fill();
    test_reset_mid_payload();
    test_random_frames();
`ifdef HDC_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
